// File: rtl/button_mode_select.sv
// button_mode_select: front-panel mode selector.
// Synchronises and debounces NUM_BTNS raw push-buttons, emits one-cycle press
// pulses and latches mode = (lowest pressed index + 1) with a change strobe.
// Optional feature macro: MODE_LOCK_EN (lock input inhibits mode updates).
module button_mode_select #(
  parameter int unsigned NUM_BTNS     = 3,
  parameter int unsigned DEB_CYCLES   = 500000,
  parameter int unsigned MODE_W       = 32,
  parameter int unsigned DEFAULT_MODE = 1
) (
  input  logic                clock,
  input  logic                anti_reset,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic                lock,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [MODE_W-1:0]   mode,
  output logic                mode_valid,
  output logic                mode_change
);

  localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  if (NUM_BTNS < 1 || NUM_BTNS > 16) begin : g_bad_num_btns
    $error("button_mode_select: NUM_BTNS must be in 1..16");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("button_mode_select: DEB_CYCLES must be >= 1");
  end
  if (MODE_W < $clog2(NUM_BTNS + 2)) begin : g_bad_mode_w
    $error("button_mode_select: MODE_W too narrow to hold NUM_BTNS+1");
  end

  logic [NUM_BTNS-1:0] r_sync1;
  logic [NUM_BTNS-1:0] r_sync2;
  logic [NUM_BTNS-1:0] r_level;
  logic [NUM_BTNS-1:0] r_level_d;
  logic [NUM_BTNS-1:0] r_press;
  logic [CNT_W-1:0]    r_cnt [NUM_BTNS];
  logic [MODE_W-1:0]   r_mode;
  logic                r_valid;
  logic                r_change;

  logic [NUM_BTNS-1:0] w_rise;
  logic                w_sel_found;
  logic [MODE_W-1:0]   w_sel_value;
  logic                w_accept;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: accept a new level after DEB_CYCLES stable cycles
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_level <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detect and lowest-index priority pick of the pressed button.
  // The rise vector feeds both the press register and the mode logic so that
  // btn_press and mode update on the same edge.
  always_comb begin
    w_rise      = r_level & ~r_level_d;
    w_sel_found = 1'b0;
    w_sel_value = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (w_rise[i] && !w_sel_found) begin
        w_sel_found = 1'b1;
        w_sel_value = MODE_W'(i + 1);
      end
    end
  end

`ifdef MODE_LOCK_EN
  assign w_accept = w_sel_found & ~lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = lock;
  assign w_accept      = w_sel_found;
`endif

  // Registered one-cycle press pulses
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_level_d <= '0;
      r_press   <= '0;
    end else begin
      r_level_d <= r_level;
      r_press   <= w_rise;
    end
  end

  // Mode latch with sticky valid flag and change strobe
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_mode   <= MODE_W'(DEFAULT_MODE);
      r_valid  <= 1'b0;
      r_change <= 1'b0;
    end else if (w_accept) begin
      r_mode   <= w_sel_value;
      r_valid  <= 1'b1;
      r_change <= (w_sel_value != r_mode);
    end else begin
      r_change <= 1'b0;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign mode        = r_mode;
  assign mode_valid  = r_valid;
  assign mode_change = r_change;

endmodule

// File: tb/tb_button_mode_select.sv
// Testbench for button_mode_select: directed sequences, a vector table and
// randomized stimulus checked against a sliding-window behavioural model.
module tb_button_mode_select;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int DEF = 1;

  logic          clock = 1'b0;
  logic          anti_reset;
  logic [NB-1:0] btn;
  logic          lock;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [31:0]   mode;
  logic          mode_valid;
  logic          mode_change;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  button_mode_select #(
    .NUM_BTNS(3),
    .DEB_CYCLES(4),
    .MODE_W(32),
    .DEFAULT_MODE(1)
  ) dut (
    .clock(clock),
    .anti_reset(anti_reset),
    .btn(btn),
    .lock(lock),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .mode(mode),
    .mode_valid(mode_valid),
    .mode_change(mode_change)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // A level is accepted when the last DEB synchronised samples (raw samples
  // delayed two edges) all differ from the current level. A press appears
  // one edge after the level rose.
  typedef struct {
    logic [NB-1:0] level;
    logic [NB-1:0] rose;
    logic [NB-1:0] press;
    logic [31:0]   mode;
    logic          valid;
    logic          change;
  } m_t;

  logic [NB-1:0] hist[$];
  m_t m;

  function automatic m_t model_reset();
    m_t r;
    r.level = '0; r.rose = '0; r.press = '0;
    r.mode = DEF; r.valid = 1'b0; r.change = 1'b0;
    return r;
  endfunction

  function automatic m_t model_step(m_t cur, logic lk, int n);
    m_t nx = cur;
    bit all_diff;
    bit eligible;
    int idx;
    int w;
    logic s;
    for (int i = 0; i < NB; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        idx = n - 2 - k;
        s = (idx < 0) ? 1'b0 : hist[idx][i];
        if (s == cur.level[i]) all_diff = 1'b0;
      end
      if (all_diff) nx.level[i] = ~cur.level[i];
    end
    nx.press  = cur.rose;
    nx.rose   = nx.level & ~cur.level;
    nx.change = 1'b0;
    eligible  = (cur.rose != '0);
`ifdef MODE_LOCK_EN
    if (lk) eligible = 1'b0;
`else
    if (lk) eligible = eligible;
`endif
    if (eligible) begin
      w = NB;
      for (int i = NB - 1; i >= 0; i--) if (cur.rose[i]) w = i;
      nx.mode   = w + 1;
      nx.change = (nx.mode != cur.mode);
      nx.valid  = 1'b1;
    end
    return nx;
  endfunction

  always @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      hist.delete();
      m <= model_reset();
    end else begin
      hist.push_back(btn);
      m <= model_step(m, lock, hist.size() - 1);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_level", 32'(btn_level), 32'(m.level));
      chk("model_press", 32'(btn_press), 32'(m.press));
      chk("model_mode", mode, m.mode);
      chk("model_valid", 32'(mode_valid), 32'(m.valid));
      chk("model_change", 32'(mode_change), 32'(m.change));
    end
  end

  // Running totals of pulse cycles for the vector table
  int tot_press = 0;
  int tot_chg   = 0;
  always @(negedge clock) begin
    if (|btn_press) tot_press <= tot_press + 1;
    if (mode_change) tot_chg <= tot_chg + 1;
  end

  typedef struct {
    logic [NB-1:0] b;
    logic          lk;
    int            cyc;
    logic [NB-1:0] lvl;
    logic [31:0]   md;
    logic          vld;
    int            np;
    int            nc;
  } vec_t;

  vec_t vec[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0;
    int hold;
`ifdef MODE_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif
    vec[0]  = '{3'b000, 1'b0, 10, 3'b000, 3, 1'b1, 0, 0};
    vec[1]  = '{3'b010, 1'b0, 3,  3'b000, 3, 1'b1, 0, 0};
    vec[2]  = '{3'b000, 1'b0, 1,  3'b000, 3, 1'b1, 0, 0};
    vec[3]  = '{3'b010, 1'b0, 3,  3'b000, 3, 1'b1, 0, 0};
    vec[4]  = '{3'b000, 1'b0, 1,  3'b000, 3, 1'b1, 0, 0};
    vec[5]  = '{3'b010, 1'b0, 3,  3'b000, 3, 1'b1, 0, 0};
    vec[6]  = '{3'b000, 1'b0, 10, 3'b000, 3, 1'b1, 0, 0};
    vec[7]  = '{3'b101, 1'b0, 10, 3'b101, 1, 1'b1, 1, 1};
    vec[8]  = '{3'b000, 1'b0, 10, 3'b000, 1, 1'b1, 0, 0};
    vec[9]  = '{3'b010, 1'b0, 10, 3'b010, 2, 1'b1, 1, 1};
    vec[10] = '{3'b000, 1'b0, 10, 3'b000, 2, 1'b1, 0, 0};
    vec[11] = '{3'b010, 1'b0, 10, 3'b010, 2, 1'b1, 1, 0};
    vec[12] = '{3'b000, 1'b0, 10, 3'b000, 2, 1'b1, 0, 0};
    vec[13] = '{3'b100, 1'b1, 10, 3'b100, LK ? 2 : 3, 1'b1, 1, LK ? 0 : 1};
    vec[14] = '{3'b000, 1'b0, 10, 3'b000, LK ? 2 : 3, 1'b1, 0, 0};
    vec[15] = '{3'b100, 1'b0, 10, 3'b100, 3, 1'b1, 1, LK ? 1 : 0};
    vec[16] = '{3'b000, 1'b0, 10, 3'b000, 3, 1'b1, 0, 0};

    anti_reset = 1'b0;
    btn        = '0;
    lock       = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_mode", mode, 32'd1);
    chk("reset_valid", 32'(mode_valid), 32'd0);
    chk("reset_level", 32'(btn_level), 32'd0);
    chk_en = 1'b1;
    tick();
    anti_reset = 1'b1;

    // Idle after reset: nothing moves
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_press", 32'(btn_press), 32'd0);
      chk("idle_change", 32'(mode_change), 32'd0);
      chk("idle_mode", mode, 32'd1);
      chk("idle_valid", 32'(mode_valid), 32'd0);
    end

    // btn[2] held: level at edge 5, press/mode/valid/change at edge 6
    btn = 3'b100;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk("b2_level", 32'(btn_level), (e >= 5) ? 32'd4 : 32'd0);
      chk("b2_press", 32'(btn_press), (e == 6) ? 32'd4 : 32'd0);
      chk("b2_change", 32'(mode_change), (e == 6) ? 32'd1 : 32'd0);
      chk("b2_mode", mode, (e >= 6) ? 32'd3 : 32'd1);
      chk("b2_valid", 32'(mode_valid), (e >= 6) ? 32'd1 : 32'd0);
    end

    // Vector table: glitches, simultaneous presses, re-press, lock
    for (int v = 0; v < 17; v++) begin
      btn  = vec[v].b;
      lock = vec[v].lk;
      p0 = tot_press;
      c0 = tot_chg;
      repeat (vec[v].cyc) tick();
      chk($sformatf("vec%0d_level", v), 32'(btn_level), 32'(vec[v].lvl));
      chk($sformatf("vec%0d_mode", v), mode, vec[v].md);
      chk($sformatf("vec%0d_valid", v), 32'(mode_valid), 32'(vec[v].vld));
      chk($sformatf("vec%0d_npress", v), 32'(tot_press - p0), 32'(vec[v].np));
      chk($sformatf("vec%0d_nchange", v), 32'(tot_chg - c0), 32'(vec[v].nc));
    end

    // Reset mid-debounce: partial count discarded, async clear, no late pulse
    btn = 3'b001;
    repeat (3) tick();
    anti_reset = 1'b0;
    #1;
    chk("arst_mode", mode, 32'd1);
    chk("arst_valid", 32'(mode_valid), 32'd0);
    chk("arst_level", 32'(btn_level), 32'd0);
    btn = 3'b000;
    repeat (2) tick();
    anti_reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("post_rst_press", 32'(btn_press), 32'd0);
      chk("post_rst_level", 32'(btn_level), 32'd0);
      chk("post_rst_mode", mode, 32'd1);
    end

    // Randomized stimulus against the model
    for (int it = 0; it < 400; it++) begin
      btn  = NB'($urandom_range(0, 7));
      lock = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 49) == 0) begin
        anti_reset = 1'b0;
        repeat (2) tick();
        anti_reset = 1'b1;
      end
      repeat (hold) tick();
    end

    btn  = '0;
    lock = 1'b0;
    repeat (12) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
